// File: rtl/ant_select_n_pkg.sv
// Shared definitions for the N-antenna selection controller: state encoding,
// phase width and a lane extractor for packed per-antenna phase vectors.
package ant_sel_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    COLLECT = 2'd1,
    FIX     = 2'd2
  } ant_state_e;

  localparam int PHASE_W    = 32;
  localparam int MAX_ANT    = 8;
  localparam int LANE_IDX_W = 3;

  // Callers zero-extend their packed vector to MAX_ANT lanes first.
  function automatic logic [PHASE_W-1:0] phase_lane(
    input logic [MAX_ANT*PHASE_W-1:0] vec,
    input logic [LANE_IDX_W-1:0]      idx
  );
    phase_lane = vec[idx*PHASE_W +: PHASE_W];
  endfunction

endpackage

// File: rtl/ant_select_n_rssi_argmax.sv
// Combinational argmax over the masked per-antenna RSSI lanes; the lowest
// index wins ties and any_valid flags a non-empty mask.
module ant_rssi_argmax
  #(
    parameter int NUM_ANT    = 4,
    parameter int RSSI_WIDTH = 11,
    parameter int IDX_W      = 2
  )
  (
    input  logic [NUM_ANT-1:0]            valid,
    input  logic [NUM_ANT*RSSI_WIDTH-1:0] rssi,
    output logic [IDX_W-1:0]              idx,
    output logic                          any_valid
  );

  logic [IDX_W-1:0]      best_idx_s;
  logic [RSSI_WIDTH-1:0] best_val_s;
  logic                  found_s;
  logic                  take_s;

  // Linear scan; a strict greater-than keeps the earlier lane on ties.
  always_comb begin
    best_idx_s = '0;
    best_val_s = '0;
    found_s    = 1'b0;
    take_s     = 1'b0;
    for (int k = 0; k < NUM_ANT; k++) begin
      take_s     = valid[k] & (~found_s | (rssi[k*RSSI_WIDTH +: RSSI_WIDTH] > best_val_s));
      best_idx_s = take_s ? IDX_W'(k) : best_idx_s;
      best_val_s = take_s ? rssi[k*RSSI_WIDTH +: RSSI_WIDTH] : best_val_s;
      found_s    = found_s | take_s;
    end
  end

  assign idx       = best_idx_s;
  assign any_valid = found_s;

endmodule

// File: rtl/ant_select_n.sv
// N-antenna selection controller: picks the strongest detecting antenna within
// an observation window (with RSSI hysteresis) and emits one merged detection.
// Optional per-antenna commit statistics: define ANT_SEL_STATS_EN.
module ant_select_n
  import ant_sel_pkg::*;
  #(
    parameter int NUM_ANT       = 4,
    parameter int ANT_IDX_W     = 2,
    parameter int RSSI_WIDTH    = 11,
    parameter int TIMEOUT_WIDTH = 4,
    parameter int HYST_HALF_DB  = 2
  )
  (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_ANT*RSSI_WIDTH-1:0] rssi_half_db,
    input  logic [NUM_ANT-1:0]            power_trigger,
    input  logic [NUM_ANT-1:0]            preamble_det,
    input  logic [NUM_ANT*PHASE_W-1:0]    phase_offset_in,
    input  logic [TIMEOUT_WIDTH-1:0]      window_len,
    output logic                          short_preamble_detected,
    output logic [ANT_IDX_W-1:0]          ant_select,
    output logic [PHASE_W-1:0]            phase_offset,
    output logic                          locked
`ifdef ANT_SEL_STATS_EN
    ,
    input  logic                          stats_clear,
    output logic [NUM_ANT*16-1:0]         sel_count
`endif
  );

  localparam int W = RSSI_WIDTH;

  ant_state_e                 state_r, state_nxt_s;
  logic [ANT_IDX_W-1:0]       cand_r, cand_nxt_s;
  logic [TIMEOUT_WIDTH-1:0]   cnt_r, cnt_nxt_s, cnt_inc_s;
  logic                       pulse_r, pulse_nxt_s;
  logic                       locked_r, locked_nxt_s;
  logic [PHASE_W-1:0]         phase_r, phase_nxt_s;
  logic                       illegal_s;
  logic [NUM_ANT-1:0]         det_s, qual_s;
  logic [W-1:0]               cand_rssi_s;
  logic                       cand_pwr_s;
  logic [ANT_IDX_W-1:0]       best_idx_s, chal_idx_s;
  logic                       best_any_s, chal_any_s;
  logic [MAX_ANT*PHASE_W-1:0] phase_ext_s;

  assign det_s       = preamble_det & power_trigger;
  assign cand_rssi_s = rssi_half_db[cand_r*W +: W];
  assign cand_pwr_s  = power_trigger[cand_r];
  assign phase_ext_s = (MAX_ANT*PHASE_W)'(phase_offset_in);
  assign cnt_inc_s   = (cnt_r == '1) ? cnt_r : cnt_r + TIMEOUT_WIDTH'(1);

  // Challengers must beat the candidate by more than the hysteresis margin; one extra bit avoids wrap.
  always_comb begin
    qual_s = '0;
    for (int j = 0; j < NUM_ANT; j++) begin
      qual_s[j] = det_s[j] & (ANT_IDX_W'(j) != cand_r) &
                  ({1'b0, rssi_half_db[j*W +: W]} > ({1'b0, cand_rssi_s} + (W+1)'(HYST_HALF_DB)));
    end
  end

  ant_rssi_argmax #(.NUM_ANT(NUM_ANT), .RSSI_WIDTH(W), .IDX_W(ANT_IDX_W)) u_pick (
    .valid     (det_s),
    .rssi      (rssi_half_db),
    .idx       (best_idx_s),
    .any_valid (best_any_s)
  );

  ant_rssi_argmax #(.NUM_ANT(NUM_ANT), .RSSI_WIDTH(W), .IDX_W(ANT_IDX_W)) u_chal (
    .valid     (qual_s),
    .rssi      (rssi_half_db),
    .idx       (chal_idx_s),
    .any_valid (chal_any_s)
  );

  // Next-state, candidate, counter and output decode.
  always_comb begin
    state_nxt_s  = state_r;
    cand_nxt_s   = cand_r;
    cnt_nxt_s    = cnt_r;
    pulse_nxt_s  = 1'b0;
    locked_nxt_s = locked_r;
    illegal_s    = 1'b0;
    case (state_r)
      WAIT: begin
        cnt_nxt_s    = '0;
        locked_nxt_s = 1'b0;
        if (best_any_s) begin
          cand_nxt_s = best_idx_s;
          if (window_len == '0) begin
            state_nxt_s  = FIX;
            pulse_nxt_s  = 1'b1;
            locked_nxt_s = 1'b1;
          end else begin
            state_nxt_s = COLLECT;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      COLLECT: begin
        cnt_nxt_s = cnt_inc_s;
        if (!cand_pwr_s) begin
          state_nxt_s = WAIT;
        end else begin
          if (chal_any_s) begin
            cand_nxt_s = chal_idx_s;
          end else begin
            cand_nxt_s = cand_r;
          end
          if (cnt_r == window_len - TIMEOUT_WIDTH'(1)) begin
            state_nxt_s  = FIX;
            pulse_nxt_s  = 1'b1;
            locked_nxt_s = 1'b1;
          end else begin
            state_nxt_s = COLLECT;
          end
        end
      end
      FIX: begin
        if (!cand_pwr_s) begin
          state_nxt_s  = WAIT;
          locked_nxt_s = 1'b0;
        end else begin
          state_nxt_s  = FIX;
          locked_nxt_s = 1'b1;
        end
      end
      default: begin
        illegal_s    = 1'b1;
        state_nxt_s  = WAIT;
        cand_nxt_s   = '0;
        cnt_nxt_s    = '0;
        locked_nxt_s = 1'b0;
      end
    endcase
    if (illegal_s) begin
      phase_nxt_s = '0;
    end else begin
      phase_nxt_s = phase_lane(phase_ext_s, LANE_IDX_W'(cand_nxt_s));
    end
  end

  // State and output registers; a disabled cycle holds everything but drops the pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= WAIT;
      cand_r   <= '0;
      cnt_r    <= '0;
      pulse_r  <= 1'b0;
      locked_r <= 1'b0;
      phase_r  <= '0;
    end else if (!enable) begin
      pulse_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cand_r   <= cand_nxt_s;
      cnt_r    <= cnt_nxt_s;
      pulse_r  <= pulse_nxt_s;
      locked_r <= locked_nxt_s;
      phase_r  <= phase_nxt_s;
    end
  end

  assign short_preamble_detected = pulse_r;
  assign ant_select              = cand_r;
  assign phase_offset            = phase_r;
  assign locked                  = locked_r;

`ifdef ANT_SEL_STATS_EN
  for (genvar k = 0; k < NUM_ANT; k++) begin : g_stats
    logic [15:0] commit_cnt_r;
    // Saturating count of commits to antenna k.
    always_ff @(posedge clock) begin
      if (reset || stats_clear) begin
        commit_cnt_r <= 16'd0;
      end else if (enable && pulse_nxt_s && (cand_nxt_s == ANT_IDX_W'(k)) && (commit_cnt_r != 16'hFFFF)) begin
        commit_cnt_r <= commit_cnt_r + 16'd1;
      end else begin
        commit_cnt_r <= commit_cnt_r;
      end
    end
    assign sel_count[k*16 +: 16] = commit_cnt_r;
  end
`endif

endmodule

// File: tb/tb_ant_select_n.sv
// Directed, table-driven bench for ant_select_n (default parameters).
module tb_ant_select_n;

  logic         clock;
  logic         reset;
  logic         enable;
  logic [43:0]  rssi_half_db;
  logic [3:0]   power_trigger;
  logic [3:0]   preamble_det;
  logic [127:0] phase_offset_in;
  logic [3:0]   window_len;
  logic         short_preamble_detected;
  logic [1:0]   ant_select;
  logic [31:0]  phase_offset;
  logic         locked;
`ifdef ANT_SEL_STATS_EN
  logic         stats_clear;
  logic [63:0]  sel_count;
`endif

  int n_checks;
  int n_fail;
  int row_id;

  typedef struct {
    logic        en;
    logic [3:0]  pt;
    logic [3:0]  pd;
    logic [10:0] r0, r1, r2, r3;
    logic [3:0]  wl;
    logic        e_pulse;
    logic [1:0]  e_sel;
    logic        e_lock;
  } vec_t;

  vec_t tbl[$];

  ant_select_n dut (
    .clock                   (clock),
    .reset                   (reset),
    .enable                  (enable),
    .rssi_half_db            (rssi_half_db),
    .power_trigger           (power_trigger),
    .preamble_det            (preamble_det),
    .phase_offset_in         (phase_offset_in),
    .window_len              (window_len),
    .short_preamble_detected (short_preamble_detected),
    .ant_select              (ant_select),
    .phase_offset            (phase_offset),
    .locked                  (locked)
`ifdef ANT_SEL_STATS_EN
    ,
    .stats_clear             (stats_clear),
    .sel_count               (sel_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] lane_val(input logic [1:0] k);
    lane_val = 32'hC0DE_0000 | {30'd0, k};
  endfunction

  function automatic vec_t mk(input logic en, input logic [3:0] pt, input logic [3:0] pd,
                              input int r0, input int r1, input int r2, input int r3,
                              input logic [3:0] wl, input logic ep, input logic [1:0] es,
                              input logic el);
    vec_t v;
    v.en = en; v.pt = pt; v.pd = pd;
    v.r0 = 11'(r0); v.r1 = 11'(r1); v.r2 = 11'(r2); v.r3 = 11'(r3);
    v.wl = wl; v.e_pulse = ep; v.e_sel = es; v.e_lock = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h expected %0h", name, row_id, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input logic ep, input logic [1:0] es, input logic el, input logic [31:0] eph);
    chk("pulse", {31'd0, short_preamble_detected}, {31'd0, ep});
    chk("ant_select", {30'd0, ant_select}, {30'd0, es});
    chk("locked", {31'd0, locked}, {31'd0, el});
    chk("phase_offset", phase_offset, eph);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    row_id   = -1;
    for (int k = 0; k < 4; k++) phase_offset_in[k*32 +: 32] = lane_val(2'(k));
    reset         = 1'b1;
    enable        = 1'b1;
    power_trigger = 4'hF;
    preamble_det  = 4'b0100;
    rssi_half_db  = {4{11'd100}};
    window_len    = 4'd4;
`ifdef ANT_SEL_STATS_EN
    stats_clear   = 1'b0;
`endif

    // Reset state, even with a detection present.
    step();
    step();
    check_out(1'b0, 2'd0, 1'b0, 32'd0);
    reset        = 1'b0;
    preamble_det = 4'b0000;

    // Single antenna, window 4
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 4, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0100, 100, 100, 100, 100, 4, 0, 2, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 4, 0, 2, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 4, 1, 2, 1));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 4, 0, 2, 1));
    tbl.push_back(mk(1, 4'b1011, 4'b0000, 100, 100, 100, 100, 4, 0, 2, 0));
    // Simultaneous detection with RSSI tie, then candidate power loss in COLLECT
    tbl.push_back(mk(1, 4'hF, 4'b1010, 100, 80, 100, 80, 4, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1101, 4'b0000, 100, 80, 100, 80, 4, 0, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 4, 0, 1, 0));
    // Hysteresis: +2 rejected, +3 takes over, window timed from first detection
    tbl.push_back(mk(1, 4'hF, 4'b0001, 100, 100, 100, 102, 4, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1000, 100, 100, 100, 102, 4, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1000, 100, 100, 100, 103, 4, 0, 3, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 103, 4, 0, 3, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 103, 4, 1, 3, 1));
    tbl.push_back(mk(1, 4'hF, 4'b0001, 500, 100, 100, 103, 4, 0, 3, 1));
    tbl.push_back(mk(1, 4'b0111, 4'b0000, 100, 100, 100, 100, 4, 0, 3, 0));
    // Fresh window after FIX loss
    tbl.push_back(mk(1, 4'hF, 4'b0010, 100, 100, 100, 100, 2, 0, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 2, 0, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 2, 1, 1, 1));
    tbl.push_back(mk(1, 4'b1101, 4'b0000, 100, 100, 100, 100, 2, 0, 1, 0));
    // Window 0: immediate commit
    tbl.push_back(mk(1, 4'hF, 4'b1000, 100, 100, 100, 100, 0, 1, 3, 1));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 0, 0, 3, 1));
    tbl.push_back(mk(1, 4'b0111, 4'b0000, 100, 100, 100, 100, 0, 0, 3, 0));
    // Enable low for 3 cycles mid-COLLECT delays the commit by 3
    tbl.push_back(mk(1, 4'hF, 4'b0001, 100, 100, 100, 100, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 3, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0000, 4'b1111, 100, 100, 100, 100, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 3, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0000, 100, 100, 100, 100, 3, 1, 0, 1));
    tbl.push_back(mk(1, 4'b1110, 4'b0000, 100, 100, 100, 100, 3, 0, 0, 0));
    // Disabled detection is ignored; disabling during the pulse clears it
    tbl.push_back(mk(0, 4'hF, 4'b0010, 100, 100, 100, 100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b0010, 100, 100, 100, 100, 0, 1, 1, 1));
    tbl.push_back(mk(0, 4'hF, 4'b0000, 100, 100, 100, 100, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b1101, 4'b0000, 100, 100, 100, 100, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      row_id        = i;
      enable        = tbl[i].en;
      power_trigger = tbl[i].pt;
      preamble_det  = tbl[i].pd;
      rssi_half_db  = {tbl[i].r3, tbl[i].r2, tbl[i].r1, tbl[i].r0};
      window_len    = tbl[i].wl;
      step();
      check_out(tbl[i].e_pulse, tbl[i].e_sel, tbl[i].e_lock, lane_val(tbl[i].e_sel));
    end

    // Reset during the FIX pulse cycle
    row_id        = 100;
    enable        = 1'b1;
    power_trigger = 4'hF;
    rssi_half_db  = {4{11'd100}};
    window_len    = 4'd0;
    preamble_det  = 4'b0100;
    step();
    check_out(1'b1, 2'd2, 1'b1, lane_val(2'd2));
    row_id       = 101;
    reset        = 1'b1;
    preamble_det = 4'b0000;
    step();
    check_out(1'b0, 2'd0, 1'b0, 32'd0);
    reset = 1'b0;

    // Reset mid-COLLECT: no pulse afterwards
    row_id       = 102;
    window_len   = 4'd2;
    preamble_det = 4'b0010;
    step();
    check_out(1'b0, 2'd1, 1'b0, lane_val(2'd1));
    row_id       = 103;
    reset        = 1'b1;
    preamble_det = 4'b0000;
    step();
    check_out(1'b0, 2'd0, 1'b0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      row_id = 104 + i;
      step();
      check_out(1'b0, 2'd0, 1'b0, lane_val(2'd0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
